// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / stall controller.
// Holds the controller state encoding and the default values of the
// memory-timeout and statistics-counter-width parameters.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam int DEF_MEM_TIMEOUT = 64;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipe_ctrl.
//   pipeline -> controller : hazard, branch_taken, mem_req, mem_ready
//   controller -> pipeline : freeze_pipe, freeze_front, flush_if, bubble_id, mem_err
//   statistics             : stall_cnt, flush_cnt, memwait_cnt (CNT_W bits each)
// master = pipeline side, slave = controller side.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             hazard;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             freeze_pipe;
  logic             freeze_front;
  logic             flush_if;
  logic             bubble_id;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] memwait_cnt;

  modport master (
    output hazard, branch_taken, mem_req, mem_ready,
    input  freeze_pipe, freeze_front, flush_if, bubble_id, mem_err,
    input  stall_cnt, flush_cnt, memwait_cnt
  );

  modport slave (
    input  hazard, branch_taken, mem_req, mem_ready,
    output freeze_pipe, freeze_front, flush_if, bubble_id, mem_err,
    output stall_cnt, flush_cnt, memwait_cnt
  );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating event counter used for the controller statistics.
//   clk, rst : clock and synchronous active-high clear
//   inc      : count one event this cycle
//   count    : current value, sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / stall / flush controller (no datapath).
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipe_ctrl_if slave -- hazard/branch/memory inputs, freeze and
//              flush controls straight to the stage registers, sticky mem_err
//              and three saturating statistics counters.
// Per-cycle priority: memory wait > taken branch > data hazard. Controls are
// combinational from the state and the current inputs; state and counters
// are registered.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  state_t            r_state;
  // Number of wait cycles already spent in the current memory access. The
  // cycle that moves RUN -> MEM_WAIT is itself a wait cycle, so the count
  // restarts at one there and ERR follows the MEM_TIMEOUT-th wait cycle.
  logic [WAIT_W-1:0] r_wait_cnt;

  logic              w_mem_wait;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_freeze_pipe;
  logic              w_freeze_front;
  logic              w_flush_if;
  logic              w_bubble_id;
  logic              w_mem_err;
  logic [CNT_W-1:0]  w_stall_cnt;
  logic [CNT_W-1:0]  w_flush_cnt;
  logic [CNT_W-1:0]  w_memwait_cnt;

  assign w_mem_wait = bus.mem_req & ~bus.mem_ready;
  assign w_wait_inc = r_wait_cnt + 1'b1;

  // RUN and MEM_WAIT share the same output rules: a ready or withdrawn
  // request in MEM_WAIT releases the freeze and lets branch/hazard act.
  always_comb begin
    w_freeze_pipe  = 1'b0;
    w_freeze_front = 1'b0;
    w_flush_if     = 1'b0;
    w_bubble_id    = 1'b0;
    w_mem_err      = 1'b0;
    if (!rst) begin
      if (r_state == ERR) begin
        w_freeze_pipe = 1'b1;
        w_mem_err     = 1'b1;
      end else if (w_mem_wait) begin
        w_freeze_pipe = 1'b1;
      end else if (bus.branch_taken) begin
        w_flush_if  = 1'b1;
        w_bubble_id = 1'b1;
      end else if (bus.hazard) begin
        w_freeze_front = 1'b1;
        w_bubble_id    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_wait) begin
            r_wait_cnt <= WAIT_ONE;
            r_state    <= (WAIT_ONE >= WAIT_LIMIT) ? ERR : MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (!w_mem_wait) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (w_wait_inc >= WAIT_LIMIT) begin
            r_state    <= ERR;
            r_wait_cnt <= w_wait_inc;
          end else begin
            r_wait_cnt <= w_wait_inc;
          end
        end
        ERR: begin
          r_state <= ERR;
        end
        default: begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // Each statistic counts exactly the cycles in which its action is driven;
  // memwait keeps counting in ERR because the pipe stays frozen there.
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_freeze_front),
    .count (w_stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush_if),
    .count (w_flush_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_memwait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_freeze_pipe),
    .count (w_memwait_cnt)
  );

  assign bus.freeze_pipe  = w_freeze_pipe;
  assign bus.freeze_front = w_freeze_front;
  assign bus.flush_if     = w_flush_if;
  assign bus.bubble_id    = w_bubble_id;
  assign bus.mem_err      = w_mem_err;
  assign bus.stall_cnt    = w_stall_cnt;
  assign bus.flush_cnt    = w_flush_cnt;
  assign bus.memwait_cnt  = w_memwait_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. Two instances run on the same stimulus:
// dut_a with default parameters (timeout 64, 16-bit counters) and dut_b with
// timeout 4 and 3-bit counters. A cycle-level reference model derived from
// the behavioural rules supplies expected values for the random test.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic fp;   // freeze_pipe
    logic ff;   // freeze_front
    logic fl;   // flush_if
    logic bub;  // bubble_id
    logic me;   // mem_err
  } ctl_t;

  logic clk;
  logic rst;

  pipe_ctrl_if #(.CNT_W(16)) if_a ();
  pipe_ctrl_if #(.CNT_W(3))  if_b ();

  pipe_ctrl #(.MEM_TIMEOUT(64), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // current stimulus
  bit t_rst, t_hz, t_br, t_rq, t_rd;

  // reference model state, index 0 = dut_a, 1 = dut_b
  int m_mt[2]   = '{64, 4};
  int m_cmax[2] = '{65535, 7};
  bit m_err[2];
  int m_run[2];
  int m_stall[2];
  int m_flush[2];
  int m_mw[2];

  function automatic ctl_t model_ctl(input int k);
    ctl_t e;
    e = '0;
    if (!t_rst) begin
      if (m_err[k]) begin
        e.fp = 1'b1;
        e.me = 1'b1;
      end else if (t_rq && !t_rd) begin
        e.fp = 1'b1;
      end else if (t_br) begin
        e.fl  = 1'b1;
        e.bub = 1'b1;
      end else if (t_hz) begin
        e.ff  = 1'b1;
        e.bub = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic int model_cnt(input int k, input int s);
    case (s)
      0:       return m_stall[k];
      1:       return m_flush[k];
      default: return m_mw[k];
    endcase
  endfunction

  function automatic void model_update();
    ctl_t e;
    for (int k = 0; k < 2; k++) begin
      e = model_ctl(k);
      if (t_rst) begin
        m_err[k]   = 1'b0;
        m_run[k]   = 0;
        m_stall[k] = 0;
        m_flush[k] = 0;
        m_mw[k]    = 0;
      end else begin
        if (e.fp && m_mw[k] < m_cmax[k])    m_mw[k]++;
        if (e.fl && m_flush[k] < m_cmax[k]) m_flush[k]++;
        if (e.ff && m_stall[k] < m_cmax[k]) m_stall[k]++;
        if (!m_err[k]) begin
          if (t_rq && !t_rd) begin
            m_run[k]++;
            if (m_run[k] >= m_mt[k]) m_err[k] = 1'b1;
          end else begin
            m_run[k] = 0;
          end
        end
      end
    end
  endfunction

  function automatic ctl_t obs(input int k);
    if (k == 0)
      return {if_a.freeze_pipe, if_a.freeze_front, if_a.flush_if, if_a.bubble_id, if_a.mem_err};
    return {if_b.freeze_pipe, if_b.freeze_front, if_b.flush_if, if_b.bubble_id, if_b.mem_err};
  endfunction

  function automatic logic [31:0] obs_cnt(input int k, input int s);
    if (k == 0) begin
      case (s)
        0:       return 32'(if_a.stall_cnt);
        1:       return 32'(if_a.flush_cnt);
        default: return 32'(if_a.memwait_cnt);
      endcase
    end
    case (s)
      0:       return 32'(if_b.stall_cnt);
      1:       return 32'(if_b.flush_cnt);
      default: return 32'(if_b.memwait_cnt);
    endcase
  endfunction

  // Apply one cycle of inputs half a period before the active edge.
  task automatic drive(input bit r, input bit h, input bit b, input bit q, input bit d);
    @(negedge clk);
    t_rst = r; t_hz = h; t_br = b; t_rq = q; t_rd = d;
    rst               = r;
    if_a.hazard       = h; if_b.hazard       = h;
    if_a.branch_taken = b; if_b.branch_taken = b;
    if_a.mem_req      = q; if_b.mem_req      = q;
    if_a.mem_ready    = d; if_b.mem_ready    = d;
    #1;
  endtask

  // Log the transaction, then let the clock edge commit it.
  task automatic tick();
    $display("t=%0t rst=%0b hz=%0b br=%0b rq=%0b rd=%0b | A ctl=%b st=%0d fl=%0d mw=%0d | B ctl=%b st=%0d fl=%0d mw=%0d",
             $time, t_rst, t_hz, t_br, t_rq, t_rd,
             obs(0), if_a.stall_cnt, if_a.flush_cnt, if_a.memwait_cnt,
             obs(1), if_b.stall_cnt, if_b.flush_cnt, if_b.memwait_cnt);
    @(posedge clk);
    model_update();
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    ctl_t c;
    logic [31:0] v;
    drive(1, 1, 1, 1, 0);
    for (int k = 0; k < 2; k++) begin
      c = obs(k);
      checks++;
      if (c !== 5'b00000) begin
        errors++;
        $display("FAIL reset_ctl dut%0d: got %b expected 00000", k, c);
      end
    end
    tick();
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) begin
        v = obs_cnt(k, s);
        checks++;
        if (v !== 32'd0) begin
          errors++;
          $display("FAIL reset_cnt%0d dut%0d: got %0d expected 0", s, k, v);
        end
      end
    end
    tick();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      c = obs(k);
      checks++;
      if (c !== 5'b00000) begin
        errors++;
        $display("FAIL idle_ctl dut%0d: got %b expected 00000", k, c);
      end
    end
    tick();
  endtask

  task automatic test_hazard();
    ctl_t c;
    logic [31:0] v;
    do_reset();
    repeat (2) begin
      drive(0, 1, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        c = obs(k);
        checks++;
        if (c !== 5'b01010) begin
          errors++;
          $display("FAIL hazard_ctl dut%0d: got %b expected 01010", k, c);
        end
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      v = obs_cnt(k, 0);
      checks++;
      if (v !== 32'd2) begin
        errors++;
        $display("FAIL hazard_stall_cnt dut%0d: got %0d expected 2", k, v);
      end
    end
    tick();
  endtask

  task automatic test_branch_vs_hazard();
    ctl_t c;
    logic [31:0] v;
    do_reset();
    drive(0, 1, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      c = obs(k);
      checks++;
      if (c !== 5'b00110) begin
        errors++;
        $display("FAIL branch_ctl dut%0d: got %b expected 00110", k, c);
      end
    end
    tick();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      v = obs_cnt(k, 1);
      checks++;
      if (v !== 32'd1) begin
        errors++;
        $display("FAIL branch_flush_cnt dut%0d: got %0d expected 1", k, v);
      end
      v = obs_cnt(k, 0);
      checks++;
      if (v !== 32'd0) begin
        errors++;
        $display("FAIL branch_stall_cnt dut%0d: got %0d expected 0", k, v);
      end
    end
    tick();
  endtask

  task automatic test_mem_wait();
    ctl_t c;
    logic [31:0] v;
    do_reset();
    repeat (3) begin
      drive(0, 1, 0, 1, 0);
      for (int k = 0; k < 2; k++) begin
        c = obs(k);
        checks++;
        if (c !== 5'b10000) begin
          errors++;
          $display("FAIL memwait_ctl dut%0d: got %b expected 10000", k, c);
        end
      end
      tick();
    end
    drive(0, 1, 0, 1, 1);
    for (int k = 0; k < 2; k++) begin
      c = obs(k);
      checks++;
      if (c !== 5'b01010) begin
        errors++;
        $display("FAIL memready_ctl dut%0d: got %b expected 01010", k, c);
      end
    end
    tick();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      v = obs_cnt(k, 2);
      checks++;
      if (v !== 32'd3) begin
        errors++;
        $display("FAIL memwait_cnt dut%0d: got %0d expected 3", k, v);
      end
      v = obs_cnt(k, 0);
      checks++;
      if (v !== 32'd1) begin
        errors++;
        $display("FAIL memwait_stall_cnt dut%0d: got %0d expected 1", k, v);
      end
    end
    tick();
  endtask

  task automatic test_timeout();
    ctl_t c;
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0);
      c = obs(1);
      checks++;
      if (c !== 5'b10000) begin
        errors++;
        $display("FAIL timeout_wait%0d dut1: got %b expected 10000", i, c);
      end
      tick();
    end
    // dut_b is now in error; mem_ready pulses and hazard/branch must be ignored
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 1, i[0]);
      c = obs(1);
      checks++;
      if (c !== 5'b10001) begin
        errors++;
        $display("FAIL timeout_err%0d dut1: got %b expected 10001", i, c);
      end
      c = obs(0);
      checks++;
      if (c !== model_ctl(0)) begin
        errors++;
        $display("FAIL timeout_ref%0d dut0: got %b expected %b", i, c, model_ctl(0));
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    c = obs(1);
    checks++;
    if (c !== 5'b10001) begin
      errors++;
      $display("FAIL timeout_sticky dut1: got %b expected 10001", c);
    end
    v = obs_cnt(1, 2);
    checks++;
    if (v !== 32'd7) begin
      errors++;
      $display("FAIL timeout_memwait_cnt dut1: got %0d expected 7", v);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    ctl_t c;
    logic [31:0] v;
    do_reset();
    repeat (5) begin
      drive(0, 0, 0, 1, 0);
      tick();
    end
    drive(1, 0, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      v = obs_cnt(k, 2);
      checks++;
      if (v !== 32'd5) begin
        errors++;
        $display("FAIL midrst_pre_mw dut%0d: got %0d expected 5", k, v);
      end
      c = obs(k);
      checks++;
      if (c !== 5'b00000) begin
        errors++;
        $display("FAIL midrst_ctl dut%0d: got %b expected 00000", k, c);
      end
    end
    tick();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      c = obs(k);
      checks++;
      if (c !== 5'b00000) begin
        errors++;
        $display("FAIL midrst_post_ctl dut%0d: got %b expected 00000", k, c);
      end
      for (int s = 0; s < 3; s++) begin
        v = obs_cnt(k, s);
        checks++;
        if (v !== 32'd0) begin
          errors++;
          $display("FAIL midrst_cnt%0d dut%0d: got %0d expected 0", s, k, v);
        end
      end
    end
    tick();
    drive(0, 0, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      c = obs(k);
      checks++;
      if (c !== 5'b10000) begin
        errors++;
        $display("FAIL midrst_rewait dut%0d: got %b expected 10000", k, c);
      end
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 0, 0);
      if (i > 0) begin
        v = obs_cnt(1, 0);
        checks++;
        if (v !== 32'((i > 7) ? 7 : i)) begin
          errors++;
          $display("FAIL sat_stall%0d dut1: got %0d expected %0d", i, v, (i > 7) ? 7 : i);
        end
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    v = obs_cnt(1, 0);
    checks++;
    if (v !== 32'd7) begin
      errors++;
      $display("FAIL sat_stall_final dut1: got %0d expected 7", v);
    end
    v = obs_cnt(0, 0);
    checks++;
    if (v !== 32'd10) begin
      errors++;
      $display("FAIL sat_stall_final dut0: got %0d expected 10", v);
    end
    tick();
  endtask

  task automatic test_random();
    ctl_t c;
    ctl_t e;
    logic [31:0] v;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 59) == 0),
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 3) == 0));
      for (int k = 0; k < 2; k++) begin
        c = obs(k);
        e = model_ctl(k);
        checks++;
        if (c !== e) begin
          errors++;
          $display("FAIL rand_ctl cyc%0d dut%0d: got %b expected %b", n, k, c, e);
        end
        for (int s = 0; s < 3; s++) begin
          v = obs_cnt(k, s);
          checks++;
          if (v !== 32'(model_cnt(k, s))) begin
            errors++;
            $display("FAIL rand_cnt%0d cyc%0d dut%0d: got %0d expected %0d",
                     s, n, k, v, model_cnt(k, s));
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    if_a.hazard = 1'b0; if_a.branch_taken = 1'b0; if_a.mem_req = 1'b0; if_a.mem_ready = 1'b0;
    if_b.hazard = 1'b0; if_b.branch_taken = 1'b0; if_b.mem_req = 1'b0; if_b.mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 1'b0; m_run[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_mw[k] = 0;
    end
    test_reset();
    test_hazard();
    test_branch_vs_hazard();
    test_mem_wait();
    test_timeout();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameters: MEM_TIMEOUT, default 64, max consecutive memory-wait cycles before error; CNT_W, default 16, statistics counter width.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 hazard  in  1  data hazard detected in ID (source reg matches a pending EXE/MEM destination).
REQ-005 branch_taken  in  1  taken branch resolved in EXE this cycle.
REQ-006 mem_req  in  1  MEM stage is issuing a load/store to data memory.
REQ-007 mem_ready  in  1  data memory completes the access this cycle.
REQ-008 freeze_pipe  out  1  hold PC and every pipeline register (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
REQ-009 freeze_front  out  1  hold PC and IF/ID register only.
REQ-010 flush_if  out  1  clear IF/ID register to a NOP.
REQ-011 bubble_id  out  1  load a NOP into ID/EXE register.
REQ-012 mem_err  out  1  sticky memory-timeout error.
REQ-013 stall_cnt / flush_cnt / memwait_cnt  out  CNT_W each  hazard-stall cycles / branch flushes / memory-wait cycles.

Function
REQ-014 FSM states: RUN, MEM_WAIT, ERR; control outputs combinational from state and current inputs, counters registered.
REQ-015 Priority per cycle: memory wait > branch > hazard; at most one action class active.
REQ-016 Memory wait: mem_req=1 and mem_ready=0 -> freeze_pipe=1, all other control outputs 0.
REQ-017 RUN to MEM_WAIT on mem_req=1, mem_ready=0; MEM_WAIT to RUN on mem_ready=1.
REQ-018 MEM_WAIT to RUN on mem_req=0 (request withdrawn), with freeze_pipe=0 in that cycle.
REQ-019 Cycle with mem_ready=1: freeze_pipe=0; branch/hazard rules apply in that same cycle.
REQ-020 Branch, no memory wait: branch_taken=1 -> flush_if=1, bubble_id=1, freeze_front=0, hazard ignored.
REQ-021 Hazard, no memory wait, no branch: hazard=1 -> freeze_front=1, bubble_id=1, flush_if=0.
REQ-022 Wait counter, width clog2(MEM_TIMEOUT+1): cleared on entering MEM_WAIT, increments each MEM_WAIT cycle.
REQ-023 Wait counter equals MEM_TIMEOUT while still waiting -> enter ERR next cycle.
REQ-024 ERR: freeze_pipe=1, mem_err=1, all other control outputs 0, inputs ignored; exit only by rst.
REQ-025 Counter update rules (each counter saturates at 2^CNT_W-1, never wraps):
- stall_cnt +1 per cycle REQ-021 applies.
- flush_cnt +1 per cycle REQ-020 applies.
- memwait_cnt +1 per cycle REQ-016 applies, including in ERR.

Reset
REQ-026 rst=1 at a clock edge sets state RUN, wait counter 0, mem_err 0, all statistics counters 0, regardless of state (including ERR, MEM_WAIT).
REQ-027 During a cycle with rst asserted, control outputs are driven as in RUN with all inputs treated as 0 (all outputs 0).

Structure
REQ-028 Shared package holds the state enumeration (RUN, MEM_WAIT, ERR) and the default MEM_TIMEOUT and CNT_W constants.
REQ-029 One sub-module, sat_counter (parameter width, inputs clk, rst, inc; output count), instantiated three times for the statistics counters.
REQ-030 Block contains no datapath; freeze/flush outputs drive the existing pipeline-stage registers' freeze and flush inputs directly.

Verification
REQ-031 Hazard: hazard=1 for 2 cycles, other inputs 0 -> freeze_front=1, bubble_id=1 both cycles; stall_cnt=2.
REQ-032 Branch vs hazard: branch_taken=1, hazard=1 same cycle -> flush_if=1, bubble_id=1, freeze_front=0; flush_cnt=1, stall_cnt unchanged.
REQ-033 Memory wait: mem_req=1 with mem_ready low 3 cycles then high, hazard=1 throughout -> freeze_pipe=1 for 3 cycles, then freeze_front=1 on the ready cycle; memwait_cnt=3, stall_cnt=1.
REQ-034 Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ready=0 held -> ERR after the 4th wait cycle, mem_err=1 and freeze_pipe=1 stay high while mem_ready later pulses.
REQ-035 Reset mid-operation: rst=1 for one cycle while in MEM_WAIT with memwait_cnt=5 -> next cycle state RUN, all counters 0, mem_err 0.
REQ-036 Saturation with CNT_W=3: hazard=1 for 10 cycles -> stall_cnt reaches 7 and holds at 7.
